// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op and state encodings and the divide-by-zero quotient.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Quotient reported on divide by zero, sliced to the operand width.
    localparam logic [63:0] DIVZ_QUOT = '1;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, width-generic.
// Used for the product, the quotient and the remainder sign fix-up.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign result = neg ? (~value + ONE) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu engine with start/busy/done handshake.
// One bit per cycle in CALC, sign fix-up in FIX, result pulse in DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   opa_raw;
    logic               is_div;
    logic               neg_pq;
    logic               neg_r;
    logic               divz;

    logic               accept;
    logic               in_div;
    logic               in_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = start && !cancel
                     && (state == IDLE || state == DONE);
    assign in_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign in_signed = (op == MD_MULT) || (op == MD_DIV);
    assign sa        = in_signed && opa[WIDTH-1];
    assign sb        = in_signed && opb[WIDTH-1];
    assign a_mag     = sa ? (~opa + ONE) : opa;
    assign b_mag     = sb ? (~opb + ONE) : opb;

    // Multiply step: add multiplicand when the low multiplier bit is set.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide step: shift in next dividend bit and trial-subtract divisor.
    assign shifted = {rem, acc[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd};

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .value  (acc),
        .neg    (neg_pq),
        .result (prod_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quot (
        .value  (acc[WIDTH-1:0]),
        .neg    (neg_pq),
        .result (quot_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .value  (rem),
        .neg    (neg_r),
        .result (rem_fix)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cancel while busy returns to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (cancel) state_nxt = IDLE;
                else if (cnt == LAST) state_nxt = FIX;
            end
            FIX:  state_nxt = cancel ? IDLE : DONE;
            DONE: state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at acceptance and one iteration per CALC cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opnd    <= '0;
            opa_raw <= '0;
            is_div  <= 1'b0;
            neg_pq  <= 1'b0;
            neg_r   <= 1'b0;
            divz    <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            opa_raw <= opa;
            is_div  <= in_div;
            neg_pq  <= sa ^ sb;
            neg_r   <= sa;
            divz    <= (opb == '0);
            opnd    <= in_div ? b_mag : a_mag;
            acc     <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    rem             <= diff[WIDTH-1:0];
                    acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
                end else begin
                    rem             <= shifted[WIDTH-1:0];
                    acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= {sum, acc[WIDTH-1:1]};
            end
        end
    end

    // Result registers update only on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (state == FIX && !cancel) begin
            if (!is_div) begin
                hi       <= prod_fix[2*WIDTH-1:WIDTH];
                lo       <= prod_fix[WIDTH-1:0];
                div_zero <= 1'b0;
            end else if (divz) begin
                hi       <= opa_raw;
                lo       <= DIVZ_QUOT[WIDTH-1:0];
                div_zero <= 1'b1;
            end else begin
                hi       <= rem_fix;
                lo       <= quot_fix;
                div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops.
// Inputs change 1ns after the rising edge; a monitor checks on falling edges.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           c0;
        int           due;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           busy_until = 0;
    bit           mon_on = 1'b0;
    logic         rst_q = 1'b1;
    logic         cancel_q = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_q    <= rst;
        cancel_q <= cancel;
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, expv);
        end
    endtask

    // Reference results from plain arithmetic on the architectural values.
    function automatic exp_t model(logic [1:0] o, logic [W-1:0] a,
                                   logic [W-1:0] b);
        exp_t            e;
        longint          p;
        longint unsigned pu;
        int              ai;
        int              bi;
        ai = a;
        bi = b;
        e.c0 = 0;
        e.due = 0;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        if (o == MD_MULT) begin
            p = longint'(ai) * longint'(bi);
            {e.hi, e.lo} = p;
        end else if (o == MD_MULTU) begin
            pu = {32'b0, a} * {32'b0, b};
            {e.hi, e.lo} = pu;
        end else if (b == '0) begin
            e.lo = '1;
            e.hi = a;
            e.dz = 1'b1;
        end else if (o == MD_DIVU) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = '0;
        end else begin
            e.lo = 32'(ai / bi);
            e.hi = 32'(ai % bi);
        end
        return e;
    endfunction

    // Monitor: expected busy/done timing and results from the scoreboard.
    always @(negedge clk) begin
        bit   eb;
        bit   ed;
        exp_t f;
        if (mon_on) begin
            if (!rst_q) begin
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_hilo", {hi, lo}, 64'(0));
                chk("rst_dz", 64'(div_zero), 64'(0));
                m_hi = '0;
                m_lo = '0;
                while (sb.size() > 0 && sb[0].c0 < cyc) void'(sb.pop_front());
            end
            while (sb.size() > 0 && cancel_q
                   && cyc - 1 > sb[0].c0 && cyc - 1 < sb[0].due)
                void'(sb.pop_front());
            eb = 1'b0;
            ed = 1'b0;
            if (sb.size() > 0) begin
                eb = (cyc > sb[0].c0) && (cyc < sb[0].due);
                ed = (cyc == sb[0].due);
            end
            chk("busy", 64'(busy), 64'(eb));
            chk("done", 64'(done), 64'(ed));
            if (ed) begin
                f = sb.pop_front();
                chk("hi", 64'(hi), 64'(f.hi));
                chk("lo", 64'(lo), 64'(f.lo));
                chk("div_zero", 64'(div_zero), 64'(f.dz));
                m_hi = f.hi;
                m_lo = f.lo;
            end else begin
                chk("hold", {hi, lo}, {m_hi, m_lo});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        op = o;
        opa = a;
        opb = b;
        start = 1'b1;
        if (cyc >= busy_until && !cancel && rst) begin
            e = model(o, a, b);
            e.c0 = cyc;
            e.due = cyc + W + 2;
            sb.push_back(e);
            busy_until = e.due;
        end
        step();
        start = 1'b0;
        op = 2'($urandom);
        opa = $urandom;
        opb = $urandom;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        if (cyc < busy_until) busy_until = cyc + 1;
        step();
        cancel = 1'b0;
    endtask

    task automatic idle_wait();
        while (cyc < busy_until) step();
        step();
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = 32'h8000_0000;
            2: v = '1;
            3: v = W'($urandom_range(0, 15));
            4: v = W'(0) - W'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        step();
        mon_on = 1'b1;
        step();
        rst = 1'b1;
        step();

        issue(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        idle_wait();
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle_wait();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        idle_wait();
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_wait();
        issue(MD_DIVU, 32'd100, 32'd0);
        idle_wait();
        issue(MD_DIVU, 32'd100, 32'd7);
        idle_wait();

        issue(MD_MULTU, 32'd5, 32'd6);
        repeat (9) step();
        do_cancel();
        step();
        issue(MD_MULTU, 32'd5, 32'd6);
        idle_wait();

        issue(MD_MULT, 32'd7, 32'hFFFF_FFF0);
        repeat (4) step();
        issue(MD_DIVU, 32'd9, 32'd2);
        repeat (14) step();
        issue(MD_MULTU, 32'd3, 32'd3);
        idle_wait();

        issue(MD_DIV, 32'd1000, 32'd3);
        repeat (14) step();
        rst = 1'b0;
        busy_until = cyc + 1;
        step();
        rst = 1'b1;
        idle_wait();

        cancel = 1'b1;
        issue(MD_MULTU, 32'd2, 32'd2);
        cancel = 1'b0;
        step();

        issue(MD_DIV, 32'hFFFF_FF00, 32'd7);
        while (cyc < busy_until) step();
        issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
        while (cyc < busy_until) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        idle_wait();

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            while (cyc < busy_until) step();
            repeat ($urandom_range(0, 2)) step();
            o = 2'($urandom);
            a = rnd_opnd();
            b = rnd_opnd();
            if ($urandom_range(0, 9) == 0) begin
                cancel = 1'b1;
                issue(o, a, b);
                cancel = 1'b0;
            end else begin
                issue(o, a, b);
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(0, 33)) step();
                    do_cancel();
                end
            end
        end

        while (cyc < busy_until) step();
        repeat (3) step();
        chk("drain", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
